// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared types for the AES MixColumns datapath.
package aes_gf_pkg;

    // Reduction constant for x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mc_state_e;

    // Multiply by x (i.e. by 2) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by x + 1 (i.e. by 3).
    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Valid/ready bus carrying one 128-bit AES state in and one out.
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/mix_single_column.sv
// Forward MixColumns on a single 32-bit column; row-0 byte in the top bits.
module mix_single_column
    import aes_gf_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Circulant matrix {2,3,1,1} applied to the column.
    always_comb begin
        r0 = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
        r3 = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative forward MixColumns: COLS_PER_CYCLE columns per BUSY cycle,
// columns 3 down to 0, result held in DONE until the consumer takes it.
module mix_columns_iter
    import aes_gf_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              reset,
    mix_columns_iter_if.slave bus
);

    localparam int unsigned NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam int unsigned CntW      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned ChunkW    = 32 * COLS_PER_CYCLE;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;

    // Step 0 handles the most significant chunk (column 3 first).
    logic [1:0]        chunk_idx;
    logic [6:0]        chunk_lsb;
    logic [ChunkW-1:0] chunk_in;
    logic [ChunkW-1:0] chunk_out;

    assign chunk_idx = 2'(NUM_STEPS - 1) - 2'(cnt_q);
    assign chunk_lsb = 7'(32'(chunk_idx) * ChunkW);
    assign chunk_in  = work_q[chunk_lsb +: ChunkW];

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        mix_single_column u_col (
            .col_in (chunk_in[j*32 +: 32]),
            .col_out(chunk_out[j*32 +: 32])
        );
    end

    // Next-state: load in IDLE, transform one chunk per BUSY cycle, drain in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    work_d  = bus.state_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d[chunk_lsb +: ChunkW] = chunk_out;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(NUM_STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.state_out = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Randomised self-checking bench for mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mix_columns_iter_if bus1 ();
    mix_columns_iter_if bus2 ();
    mix_columns_iter_if bus4 ();

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Matrix product of each column with a circulant coefficient row.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o = '0;
        if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - r + 4) % 4], s[c*32 + 24 - 8*k +: 8]);
                o[c*32 + 24 - 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_in(input int c, input logic v, input logic [127:0] s);
        case (c)
            1:       begin bus1.in_valid = v; bus1.state_in = s; end
            2:       begin bus2.in_valid = v; bus2.state_in = s; end
            default: begin bus4.in_valid = v; bus4.state_in = s; end
        endcase
    endtask

    task automatic set_ordy(input int c, input logic r);
        case (c)
            1:       bus1.out_ready = r;
            2:       bus2.out_ready = r;
            default: bus4.out_ready = r;
        endcase
    endtask

    task automatic get_out(input int c, output logic ir, output logic ov, output logic [127:0] so);
        case (c)
            1:       begin ir = bus1.in_ready; ov = bus1.out_valid; so = bus1.state_out; end
            2:       begin ir = bus2.in_ready; ov = bus2.out_valid; so = bus2.state_out; end
            default: begin ir = bus4.in_ready; ov = bus4.out_valid; so = bus4.state_out; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present st once in_ready is seen; returns one cycle after the accept edge.
    task automatic accept(input int c, input logic [127:0] st);
        logic ir, ov;
        logic [127:0] so;
        int n = 0;
        get_out(c, ir, ov, so);
        while (!ir && n < 50) begin
            tick();
            n++;
            get_out(c, ir, ov, so);
        end
        if (!ir) check("in_ready_timeout", 128'(ir), 128'd1);
        set_in(c, 1'b1, st);
        tick();
        set_in(c, 1'b0, '0);
    endtask

    // Wait for out_valid, checking latency and result; optional junk on the input side.
    task automatic wait_done(input int c, input logic [127:0] exp, input bit junk,
                             output logic [127:0] res);
        logic ir, ov;
        logic [127:0] so;
        int lat = 0;
        get_out(c, ir, ov, so);
        while (!ov && lat < 20) begin
            if (junk) set_in(c, 1'($urandom_range(0, 1)), rand128());
            tick();
            lat++;
            get_out(c, ir, ov, so);
        end
        check($sformatf("latency_c%0d", c), 128'(lat), 128'(4 / c));
        check($sformatf("result_c%0d", c), so, exp);
        check($sformatf("in_ready_done_c%0d", c), 128'(ir), 128'd0);
        res = so;
    endtask

    // Hold out_ready low for n cycles with input noise; output must not move.
    task automatic stall(input int c, input logic [127:0] exp, input int n);
        logic ir, ov;
        logic [127:0] so;
        for (int i = 0; i < n; i++) begin
            set_ordy(c, 1'b0);
            set_in(c, 1'($urandom_range(0, 1)), rand128());
            tick();
            get_out(c, ir, ov, so);
            check("stall_out_valid", 128'(ov), 128'd1);
            check("stall_in_ready", 128'(ir), 128'd0);
            check("stall_state_out", so, exp);
        end
    endtask

    task automatic release_out(input int c);
        logic ir, ov;
        logic [127:0] so;
        set_in(c, 1'b0, '0);
        set_ordy(c, 1'b1);
        tick();
        set_ordy(c, 1'b0);
        get_out(c, ir, ov, so);
        check("release_out_valid", 128'(ov), 128'd0);
        check("release_in_ready", 128'(ir), 128'd1);
    endtask

    initial begin
        int cs [3] = '{1, 2, 4};
        logic ir, ov;
        logic [127:0] so, st, res, exp;
        logic [127:0] vec_a, vec_b, exp_a, exp_b, appb, appb_exp;

        vec_a    = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        exp_a    = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
        vec_b    = {32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'hf20a225c};
        exp_b    = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h9fdc589d};
        appb     = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        appb_exp = 128'h046681e5e0cb199a48f8d37a2806264c;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(cs[k], 1'b0, '0);
            set_ordy(cs[k], 1'b0);
        end
        repeat (3) tick();
        reset = 1'b0;

        foreach (cs[k]) begin
            get_out(cs[k], ir, ov, so);
            check("reset_in_ready", 128'(ir), 128'd1);
            check("reset_out_valid", 128'(ov), 128'd0);
            check("reset_state_out", so, 128'h0);
        end

        // Known-answer vectors and the model's own agreement with them.
        check("model_vec_a", ref_mix(vec_a, 1'b0), exp_a);
        check("model_appb", ref_mix(appb, 1'b0), appb_exp);
        foreach (cs[k]) begin
            accept(cs[k], vec_a);
            wait_done(cs[k], exp_a, 1'b0, res);
            for (int col = 0; col < 4; col++)
                check($sformatf("vec_a_col%0d", col), 128'(res[col*32 +: 32]),
                      128'(exp_a[col*32 +: 32]));
            release_out(cs[k]);
            accept(cs[k], vec_b);
            wait_done(cs[k], exp_b, 1'b0, res);
            release_out(cs[k]);
            accept(cs[k], appb);
            wait_done(cs[k], appb_exp, 1'b1, res);
            release_out(cs[k]);
        end

        // Back-pressure: ten cycles of stall with input noise.
        foreach (cs[k]) begin
            st = rand128();
            exp = ref_mix(st, 1'b0);
            accept(cs[k], st);
            wait_done(cs[k], exp, 1'b1, res);
            stall(cs[k], exp, 10);
            release_out(cs[k]);
        end

        // Output completes while a new input waits; the new input goes in one cycle later.
        begin
            logic [127:0] st2;
            st  = rand128();
            st2 = rand128();
            accept(1, st);
            wait_done(1, ref_mix(st, 1'b0), 1'b0, res);
            set_in(1, 1'b1, st2);
            set_ordy(1, 1'b1);
            tick();
            set_ordy(1, 1'b0);
            get_out(1, ir, ov, so);
            check("simul_out_valid", 128'(ov), 128'd0);
            check("simul_in_ready", 128'(ir), 128'd1);
            tick();
            set_in(1, 1'b0, '0);
            get_out(1, ir, ov, so);
            check("simul_accepted", 128'(ir), 128'd0);
            wait_done(1, ref_mix(st2, 1'b0), 1'b0, res);
            release_out(1);
        end

        // Reset while the counter sits at 2.
        accept(1, rand128());
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        get_out(1, ir, ov, so);
        check("abort_in_ready", 128'(ir), 128'd1);
        check("abort_out_valid", 128'(ov), 128'd0);
        check("abort_state_out", so, 128'h0);
        accept(1, 128'h0);
        wait_done(1, 128'h0, 1'b0, res);
        release_out(1);

        // Random regression with stalls, plus inverse round trip.
        foreach (cs[k]) begin
            for (int i = 0; i < 1000; i++) begin
                st = rand128();
                exp = ref_mix(st, 1'b0);
                accept(cs[k], st);
                wait_done(cs[k], exp, 1'($urandom_range(0, 1)), res);
                check("inverse_roundtrip", ref_mix(res, 1'b1), st);
                if ($urandom_range(0, 1) == 1) stall(cs[k], exp, $urandom_range(1, 3));
                release_out(cs[k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
